data_memory_lsu: RTL and testbench
==================================

# data_memory_lsu

Parametrised, word-organised data memory with a valid/ready request port, RV32 load/store size handling, a pipelined read path of configurable latency, and a post-reset clearing sweep. It serves as the data memory of the single-cycle/multi-cycle RISC-V core. Sub-word loads are extracted, sign- or zero-extended, and returned by the block. Stores are byte-lane masked, and misaligned or out-of-range accesses are flagged.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, ≥4.
- READ_LAT, 1: response latency in cycles after acceptance; legal range 1..4.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = skip the sweep, contents undefined.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  3  RV32 funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- req_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access fault on this response.
- busy  out  1  clear sweep in progress.

## Operation
- Storage is DEPTH_WORDS × 32 bits with 4 byte lanes, little-endian. Word index = req_addr[AW+1:2], where AW = log2(DEPTH_WORDS).
- A request is accepted on a rising edge where req_valid && req_ready. One request per cycle at most. No response backpressure.
- **Fault conditions.** Any fault gives rsp_err=1, rdata=0, no write:
  - out of range: req_addr[31:AW+2] != 0;
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0;
  - illegal size: 011, 110, 111; stores with 100/101 are also illegal.
- **Store lanes.**
  - sb writes lane addr[1:0] with wdata[7:0].
  - sh writes lanes 2*addr[1] and 2*addr[1]+1 with wdata[15:0].
  - sw writes all lanes.
  - Unwritten lanes are preserved.
- **Load extraction.**
  - lb/lbu select byte addr[1:0].
  - lh/lhu select half addr[1].
  - Sign-extend for 000/001; zero-extend for 100/101.
- **FSM states.**
  - CLEAR: idx counts 0..DEPTH_WORDS-1, writing 32'h0 per cycle; req_ready=0, busy=1. After idx=DEPTH_WORDS-1 is written, go to READY.
  - READY: req_ready=1, busy=0.
  - On reset, go to CLEAR if CLEAR_ON_RESET=1, else READY.
- Reset mid-sweep or mid-response aborts everything: idx returns to 0, the response pipeline is flushed, and in-flight responses are lost.

## Timing
- **Reset values:** req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. busy=1 while reset is high when CLEAR_ON_RESET=1, else busy=0.
- **After reset deasserts (CLEAR_ON_RESET=1):** the sweep takes exactly DEPTH_WORDS cycles. req_ready rises on the edge completing the last clear write.
- **After reset deasserts (CLEAR_ON_RESET=0):** req_ready=1 from the first edge after deassertion.
- **Writes:** committed on the accepting edge.
- **Reads:** use memory contents as of the accepting edge, before any write accepted on that same edge (none is possible). A load accepted the cycle after a store to the same word sees the store.
- **Response timing:** every accepted request, including stores and faults, produces exactly one rsp_valid pulse READ_LAT cycles after acceptance. For acceptance at edge N, rsp_valid is high during cycle N+READ_LAT.
- rsp_rdata and rsp_err are valid only while rsp_valid=1; otherwise they are 0.
- **Pipeline:** a READ_LAT-deep shift register carries {valid, err, formatted data}. Formatting happens before stage 1. Back-to-back requests yield back-to-back responses in order.
- Full throughput is one request per cycle in READY.

## Test plan
- **Reset clear:** CLEAR_ON_RESET=1, DEPTH_WORDS=16. Release reset → busy=1 and req_ready=0 for 16 cycles, then ready. lw 0x3C → rdata 0x00000000, err 0.
- **Store/load widths:** sw 0x10=0x80FF7F01, then:
  - lb 0x10 → 0x00000001
  - lb 0x13 → 0xFFFFFF80
  - lbu 0x13 → 0x00000080
  - lh 0x12 → 0xFFFF80FF
  - lhu 0x12 → 0x000080FF
- **Byte-lane masking:** sw 0x20=0xAABBCCDD; sb 0x21 wdata=0x11; sh 0x22 wdata=0x2233; lw 0x20 → 0x223311DD.
- **Faults:** each of the following → err=1, rdata=0, and the memory word is unchanged:
  - lw 0x22
  - sh 0x21
  - lw 0x00000400 with DEPTH_WORDS=256
  - req_size=011
  - sb with size 100
- **Latency/throughput:** READ_LAT=3, back-to-back sw, lw, lw to the same word. Responses land 3 cycles after each acceptance, consecutive and in order, and the first lw returns the stored value.
- **Reset mid-operation:** assert reset during the sweep at idx=5 and with 2 responses in flight → no rsp_valid after reset, and the sweep restarts from idx 0 with the full DEPTH_WORDS duration.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Word-organised data memory for the RV32 core: valid/ready request port,
// byte-lane masked stores, sign/zero-extended sub-word loads, fault flagging,
// a READ_LAT-deep response pipeline and an optional post-reset clear sweep.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | sweeping idx 0..DEPTH_WORDS-1, writing zero; no requests taken
// ST_READY | accepting one request per cycle
module data_memory_lsu #(
  parameter int DEPTH_WORDS    = 256,
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          out_of_range;
  logic          misaligned;
  logic          size_illegal;
  logic          fault;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_data;
  logic [31:0]   stage_in_data;

  logic [READ_LAT-1:0] pipe_v;
  logic [READ_LAT-1:0] pipe_e;
  logic [31:0]         pipe_d [READ_LAT];

  assign accept   = req_valid && req_ready;
  assign word_idx = req_addr[AW+1:2];
  assign rd_word  = mem[word_idx];

  // Fault classification: range, alignment and size legality
  always_comb begin
    out_of_range = (req_addr >> (AW + 2)) != 32'd0;
    misaligned   = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_size)
      3'b000, 3'b001, 3'b010: size_illegal = 1'b0;
      3'b100, 3'b101:         size_illegal = req_we;
      default:                size_illegal = 1'b1;
    endcase
    fault = out_of_range || misaligned || size_illegal;
  end

  // Store lane enables with data replicated onto every candidate lane
  always_comb begin
    case (req_size[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << req_addr[1:0];
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
      end
    endcase
  end

  // Load extraction and extension; stores and faults return zero
  always_comb begin
    byte_sel = rd_word[8*req_addr[1:0] +: 8];
    half_sel = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_size)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'h0, byte_sel};
      3'b101:  ld_data = {16'h0, half_sel};
      default: ld_data = rd_word;
    endcase
    stage_in_data = (fault || req_we) ? 32'h0 : ld_data;
  end

  // Sequencing FSM: clear sweep after reset, then ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      idx       <= '0;
      req_ready <= 1'b0;
      busy      <= CLEAR_ON_RESET;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (idx == IDX_LAST) begin
            state     <= ST_READY;
            idx       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_READY: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= ST_READY;
          req_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep writes zero, accepted legal stores write their lanes
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[idx] <= 32'h0;
    end else if (accept && req_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Response shift register; reset flushes anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v <= '0;
      pipe_e <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_d[i] <= 32'h0;
    end else begin
      pipe_v[0] <= accept;
      pipe_e[0] <= accept && fault;
      pipe_d[0] <= accept ? stage_in_data : 32'h0;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign rsp_valid = pipe_v[READ_LAT-1];
  assign rsp_err   = pipe_e[READ_LAT-1];
  assign rsp_rdata = pipe_d[READ_LAT-1];

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: directed plan cases plus random
// traffic checked against a byte-addressed reference memory.
module tb_data_memory_lsu;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int NBYTE = 4 * DEPTH;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  data_memory_lsu #(
    .DEPTH_WORDS(DEPTH),
    .READ_LAT(LAT),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_size(req_size),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count of rising edges; read only on falling edges
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [7:0] mb [NBYTE];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_fault(input bit we, input logic [31:0] addr, input logic [2:0] size);
    bit illegal;
    bit mis;
    bit oor;
    illegal = (size == 3'd3) || (size == 3'd6) || (size == 3'd7) || (we && size[2]);
    mis     = ((size[1:0] == 2'd1) && addr[0]) || ((size[1:0] == 2'd2) && (addr[1:0] != 2'd0));
    oor     = addr >= 32'(NBYTE);
    return illegal || mis || oor;
  endfunction

  // Byte-addressed little-endian reference: store n bytes, or load n bytes and extend
  task automatic model_access(input bit we, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, output logic [31:0] rd);
    int          n;
    logic [63:0] m;
    n  = 1 << size[1:0];
    rd = 32'h0;
    if (we) begin
      for (int i = 0; i < n; i++) mb[addr + 32'(i)] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) rd = rd | (32'(mb[addr + 32'(i)]) << (8 * i));
      m = (64'd1 << (8 * n)) - 64'd1;
      if (!size[2] && rd[8*n-1]) rd = rd | ~m[31:0];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NBYTE; i++) mb[i] = 8'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Drive one request; its expected response is queued once acceptance is certain
  task automatic issue(input bit we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input bit use_const = 1'b0,
                       input logic [31:0] c_data = 32'h0, input bit c_err = 1'b0);
    int          guard;
    bit          f;
    logic [31:0] rd;
    exp_t        e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    guard     = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_ready_timeout: req_ready=0 after %0d cycles, required 1", guard);
      req_valid = 1'b0;
      return;
    end
    f  = model_fault(we, addr, size);
    rd = 32'h0;
    if (!f) model_access(we, addr, size, wdata, rd);
    if (we || f) rd = 32'h0;
    // Accepted on the next edge; response occupies the cycle ending LAT edges later
    e.data = use_const ? c_data : rd;
    e.err  = use_const ? c_err : f;
    e.due  = cyc + LAT;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    sbq.delete();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_sweep();
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      if (k < DEPTH) begin
        chk("sweep_busy", 32'(busy), 32'd1);
        chk("sweep_ready", 32'(req_ready), 32'd0);
      end else begin
        chk("sweep_done_busy", 32'(busy), 32'd0);
        chk("sweep_done_ready", 32'(req_ready), 32'd1);
      end
    end
    clear_model();
  endtask

  // Monitor: pops one expectation per response strobe, checks timing and payload
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with none outstanding, required 0 (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(mon_e.due));
          chk("rsp_rdata", rsp_rdata, mon_e.data);
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end else begin
        chk("idle_rdata", rsp_rdata, 32'h0);
        chk("idle_err", 32'(rsp_err), 32'd0);
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL missing_rsp: rsp_valid=0 at cycle %0d, required 1 at cycle %0d", cyc, sbq[0].due);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          g;
    bit          we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [2:0]  legal_sizes [5];
    legal_sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_size  = 3'b010;
    req_wdata = 32'h0;
    clear_model();

    #12;
    chk("init_req_ready", 32'(req_ready), 32'd0);
    chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("init_rsp_rdata", rsp_rdata, 32'h0);
    chk("init_rsp_err", 32'(rsp_err), 32'd0);
    chk("init_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;

    // Abort the sweep once idx has reached 5, then expect a full-length sweep
    repeat (5) @(negedge clk);
    chk("midsweep_busy", 32'(busy), 32'd1);
    do_reset();
    wait_sweep();

    issue(1'b0, 32'h3C, 3'b010, 32'h0, 1'b1, 32'h0, 1'b0);

    issue(1'b1, 32'h10, 3'b010, 32'h80FF7F01, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 3'b000, 32'h0, 1'b1, 32'h00000001, 1'b0);
    issue(1'b0, 32'h13, 3'b000, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
    issue(1'b0, 32'h13, 3'b100, 32'h0, 1'b1, 32'h00000080, 1'b0);
    issue(1'b0, 32'h12, 3'b001, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0);
    issue(1'b0, 32'h12, 3'b101, 32'h0, 1'b1, 32'h000080FF, 1'b0);

    issue(1'b1, 32'h20, 3'b010, 32'hAABBCCDD, 1'b1, 32'h0, 1'b0);
    issue(1'b1, 32'h21, 3'b000, 32'h00000011, 1'b1, 32'h0, 1'b0);
    issue(1'b1, 32'h22, 3'b001, 32'h00002233, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h20, 3'b010, 32'h0, 1'b1, 32'h223311DD, 1'b0);

    issue(1'b0, 32'h22, 3'b010, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h21, 3'b001, 32'h0000FFFF, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h22, 3'b010, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h00000400, 3'b010, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h40, 3'b010, 32'h12345678, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 3'b011, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h20, 3'b100, 32'h00000055, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h20, 3'b111, 32'h00000066, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 3'b010, 32'h0, 1'b1, 32'h223311DD, 1'b0);
    issue(1'b0, 32'h3C, 3'b010, 32'h0, 1'b1, 32'h0, 1'b0);

    idle(3);
    issue(1'b1, 32'h30, 3'b010, 32'hCAFEBABE, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h30, 3'b010, 32'h0, 1'b1, 32'hCAFEBABE, 1'b0);
    issue(1'b0, 32'h30, 3'b010, 32'h0, 1'b1, 32'hCAFEBABE, 1'b0);
    idle(6);

    // Two loads in flight when reset hits: neither may appear
    issue(1'b0, 32'h10, 3'b010, 32'h0);
    issue(1'b0, 32'h20, 3'b010, 32'h0);
    do_reset();
    wait_sweep();
    issue(1'b0, 32'h10, 3'b010, 32'h0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h30, 3'b010, 32'h0, 1'b1, 32'h0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) size = legal_sizes[$urandom_range(0, 4)];
      else size = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 19))
        0:       addr = 32'(NBYTE) + 32'($urandom_range(0, 1023));
        1:       addr = $urandom | 32'h8000_0000;
        default: begin
          addr = 32'($urandom_range(0, NBYTE - 1));
          if ($urandom_range(0, 1) == 0) addr = addr & ~((32'd1 << size[1:0]) - 32'd1);
        end
      endcase
      issue(we, addr, size, $urandom);
    end

    idle(1);
    g = 0;
    while (sbq.size() > 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (sbq.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
